// File: rtl/accelerator_pkg.sv
// Shared accelerator definitions.
// Buffer geometry and controller state encoding.
package accelerator_pkg;

  localparam int ROW_NUM = 32;
  localparam int COL_NUM = 32;
  localparam int PTR_W   = 5;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/weight_load_ctrl.sv
// Weight load controller.
// Streams row beats into the horizontal buffer, one row per beat.
module weight_load_ctrl #(
  parameter int ROW_NUM = accelerator_pkg::ROW_NUM,
  parameter int COL_NUM = accelerator_pkg::COL_NUM
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           start_row,
  input  logic [5:0]           num_rows,
  input  logic                 in_valid,
  input  logic [COL_NUM*8-1:0] in_data,
  output logic                 in_ready,
  output logic [ROW_NUM-1:0]   wb_en,
  output logic [COL_NUM*8-1:0] wb_row_data,
  output logic                 busy,
  output logic                 done
);

  import accelerator_pkg::*;

  localparam logic [PTR_W-1:0] ROW_MAX = PTR_W'(ROW_NUM - 1);
  localparam logic [CNT_W-1:0] ROW_CAP = CNT_W'(ROW_NUM);

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   row_ptr;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   eff_rows;
  logic               start_hit;
  logic               accept;
  logic [ROW_NUM-1:0] row_onehot;

  // Clamp the request to the buffer depth and decode the row pointer.
  always_comb begin
    eff_rows   = (num_rows > ROW_CAP) ? ROW_CAP : num_rows;
    row_onehot = '0;
    row_onehot[row_ptr] = 1'b1;
  end

  // Next-state logic; beats are only taken while loading.
  always_comb begin
    state_next = state;
    start_hit  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_hit  = 1'b1;
          state_next = (eff_rows != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          accept = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Row pointer, remaining count and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_ptr     <= '0;
      remaining   <= '0;
      wb_en       <= '0;
      wb_row_data <= '0;
    end else begin
      wb_en <= accept ? row_onehot : '0;
      if (accept) begin
        wb_row_data <= in_data;
      end
      if (start_hit) begin
        row_ptr   <= start_row;
        remaining <= eff_rows;
      end else if (accept) begin
        row_ptr   <= (row_ptr == ROW_MAX) ? '0 : row_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Testbench for weight_load_ctrl.
// Scoreboard of accepted beats checked against write pulses.
module tb_weight_load_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic [4:0]   start_row;
  logic [5:0]   num_rows;
  logic         in_valid;
  logic [255:0] in_data;
  logic         in_ready;
  logic [31:0]  wb_en;
  logic [255:0] wb_row_data;
  logic         busy;
  logic         done;

  typedef struct {
    int           row;
    logic [255:0] data;
  } exp_t;

  exp_t q[$];
  int   seen[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   m_state  = 0;
  int   m_ptr    = 0;
  int   m_rem    = 0;

  weight_load_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_row   (start_row),
    .num_rows    (num_rows),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wb_en       (wb_en),
    .wb_row_data (wb_row_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd_row();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Advance one cycle: model the inputs, then check the outputs.
  task automatic tick();
    exp_t        e;
    logic [31:0] exp_en;
    case (m_state)
      0: if (start) begin
        m_ptr   = int'(start_row);
        m_rem   = (num_rows > 6'd32) ? 32 : int'(num_rows);
        m_state = (m_rem != 0) ? 1 : 2;
      end
      1: if (in_valid) begin
        e.row  = m_ptr;
        e.data = in_data;
        q.push_back(e);
        m_ptr = (m_ptr + 1) % 32;
        m_rem = m_rem - 1;
        if (m_rem == 0) m_state = 2;
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== (m_state == 1)) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b", in_ready, m_state == 1);
    end
    n_checks++;
    if (busy !== (m_state != 0)) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b", busy, m_state != 0);
    end
    n_checks++;
    if (done !== (m_state == 2)) begin
      n_fail++;
      $display("FAIL done: got %b expected %b", done, m_state == 2);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_en = 32'd1 << e.row;
      n_checks++;
      if (wb_en !== exp_en) begin
        n_fail++;
        $display("FAIL wb_en: got %h expected %h", wb_en, exp_en);
      end
      n_checks++;
      if (wb_row_data !== e.data) begin
        n_fail++;
        $display("FAIL wb_row_data: got %h expected %h", wb_row_data, e.data);
      end
    end else begin
      n_checks++;
      if (wb_en !== 32'd0) begin
        n_fail++;
        $display("FAIL wb_en_idle: got %h expected 0", wb_en);
      end
    end
    if (wb_en != 32'd0) begin
      pulses++;
      for (int i = 0; i < 32; i++) if (wb_en[i]) seen.push_back(i);
    end
  endtask

  task automatic go(input int row, input int n);
    start     = 1'b1;
    start_row = 5'(row);
    num_rows  = 6'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_row = '0;
    num_rows = '0;
    in_valid = 1'b0;
    in_data = '0;
    #3;
    n_checks++;
    if ({wb_en, busy, done, in_ready} !== 35'd0 || wb_row_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%h busy=%b done=%b rdy=%b expected 0",
               wb_en, busy, done, in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int p0;
    p0 = pulses;
    seen.delete();
    in_valid = 1'b1;
    in_data  = {32{8'hFF}};
    go(0, 4);
    for (int k = 1; k <= 4; k++) begin
      in_data = {32{8'(k)}};
      tick();
    end
    n_checks++;
    if (wb_en !== 32'h8 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_last: got en=%h done=%b expected en=8 done=1", wb_en, done);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_fall: got %b expected 0", busy);
    end
    n_checks++;
    if (pulses - p0 != 4 || seen.size() != 4 || seen[0] != 0 || seen[3] != 3) begin
      n_fail++;
      $display("FAIL basic_rows: got %0d pulses expected 4 rows 0..3", pulses - p0);
    end
  endtask

  task automatic test_wrap();
    int want[4] = '{30, 31, 0, 1};
    seen.delete();
    in_valid = 1'b1;
    go(30, 4);
    for (int k = 0; k < 4; k++) begin
      in_data = rnd_row();
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (seen.size() != 4 || seen[k] != want[k]) begin
        n_fail++;
        $display("FAIL wrap_row%0d: got %0d expected %0d", k,
                 (seen.size() > k) ? seen[k] : -1, want[k]);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    int p0;
    p0 = pulses;
    in_valid = 1'b1;
    in_data  = rnd_row();
    go(12, 0);
    n_checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b rdy=%b expected 1 0", done, in_ready);
    end
    tick();
    tick();
    n_checks++;
    if (pulses != p0) begin
      n_fail++;
      $display("FAIL zero_pulses: got %0d expected 0", pulses - p0);
    end
    p0 = pulses;
    go(5, 40);
    for (int k = 0; k < 36; k++) begin
      in_data = rnd_row();
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (pulses - p0 != 32) begin
      n_fail++;
      $display("FAIL clamp_pulses: got %0d expected 32", pulses - p0);
    end
  endtask

  task automatic test_stall();
    int p0;
    bit pat[4] = '{1, 0, 0, 1};
    p0 = pulses;
    seen.delete();
    in_valid = 1'b0;
    go(20, 2);
    for (int k = 0; k < 4; k++) begin
      in_valid = pat[k];
      in_data  = rnd_row();
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (pulses - p0 != 2 || seen.size() != 2 || seen[0] != 20 || seen[1] != 21) begin
      n_fail++;
      $display("FAIL stall_pulses: got %0d expected 2 rows 20,21", pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    seen.delete();
    in_valid = 1'b1;
    go(0, 5);
    for (int k = 0; k < 2; k++) begin
      in_data = rnd_row();
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({wb_en, busy, done, in_ready} !== 35'd0 || wb_row_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got en=%h busy=%b done=%b rdy=%b expected 0",
               wb_en, busy, done, in_ready);
    end
    m_state = 0;
    m_ptr = 0;
    m_rem = 0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      in_data = rnd_row();
      tick();
    end
    n_checks++;
    if (pulses != p0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: got %0d expected 0", pulses - p0);
    end
    seen.delete();
    go(7, 1);
    in_data = rnd_row();
    tick();
    n_checks++;
    if (seen.size() != 1 || seen[0] != 7 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reload: got %0d pulses done=%b expected row 7 done=1",
               seen.size(), done);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int want[3] = '{3, 4, 5};
    seen.delete();
    in_valid = 1'b1;
    go(3, 3);
    for (int k = 0; k < 3; k++) begin
      start     = (k == 1);
      start_row = 5'd9;
      num_rows  = 6'd1;
      in_data   = rnd_row();
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (seen.size() != 3 || seen[k] != want[k]) begin
        n_fail++;
        $display("FAIL start_ignored_row%0d: got %0d expected %0d", k,
                 (seen.size() > k) ? seen[k] : -1, want[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_and_clamp();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
